// File: rtl/alu_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared definitions for the ALU issue controller, its register file and the
// ALU it drives: opcode encodings, instruction field positions, FSM state
// encoding, and small decode helpers.
// ---------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

  localparam int XLEN   = 16;  // datapath width
  localparam int REG_AW = 3;   // register-field width

  // Opcode encodings understood by the ALU.
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b1010;
  localparam logic [3:0] OP_SUBI = 4'b1011;

  // Instruction field bit positions.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS_MSB  = 8;
  localparam int RS_LSB  = 6;
  localparam int RT_MSB  = 5;
  localparam int RT_LSB  = 3;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ISSUE     = 2'b01,
    ST_WRITEBACK = 2'b10
  } state_e;

  // Decoded view of an instruction word. rt and imm6 overlap in the word.
  typedef struct packed {
    logic [3:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [5:0]        imm6;
  } instr_t;

  function automatic instr_t decode(input logic [XLEN-1:0] w);
    instr_t d;
    d.opcode = w[OPC_MSB:OPC_LSB];
    d.rd     = w[RD_MSB:RD_LSB];
    d.rs     = w[RS_MSB:RS_LSB];
    d.rt     = w[RT_MSB:RT_LSB];
    d.imm6   = w[IMM_MSB:IMM_LSB];
    return d;
  endfunction

  function automatic logic is_supported(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SUBI);
  endfunction

  function automatic logic [XLEN-1:0] sext6(input logic [5:0] imm);
    return {{(XLEN-6){imm[5]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_regfile
// Architectural register file: NREGS x 16-bit, r0 hardwired to zero.
//   clk, rst           : clock, synchronous active-high reset (clears all regs)
//   we/waddr/wdata     : synchronous write port (writes to r0 discarded)
//   raddr_a/rdata_a    : asynchronous read port A
//   raddr_b/rdata_b    : asynchronous read port B
//   dbg_addr/dbg_data  : asynchronous debug read port
// Reads return the stored value only; a write is visible the cycle after.
// ---------------------------------------------------------------------------
module alu_issue_ctrl_regfile
  import alu_issue_ctrl_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [XLEN-1:0]   rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [XLEN-1:0]   rdata_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // NOTE: combinational blocks use blocking '=' and start from a full default
  // (here a copy of the current state) so no path leaves a variable unassigned
  // and no latch is inferred; the flop block below uses non-blocking '<='.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0) && (int'(waddr) < NREGS)) begin
      regs_d[waddr] = wdata;
    end
  end

  // NOTE: this array is reset explicitly because reset must clear every
  // architectural register; that keeps it out of RAM macros, which is
  // acceptable for a handful of registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // r0 and any address beyond the array read as zero.
  assign rdata_a  = ((raddr_a  != '0) && (int'(raddr_a)  < NREGS)) ? regs_q[raddr_a]  : '0;
  assign rdata_b  = ((raddr_b  != '0) && (int'(raddr_b)  < NREGS)) ? regs_q[raddr_b]  : '0;
  assign dbg_data = ((dbg_addr != '0) && (int'(dbg_addr) < NREGS)) ? regs_q[dbg_addr] : '0;

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Three-state issue controller for an external registered ALU.
//   clk, rst                  : clock, synchronous active-high reset
//   instr_valid/instr         : offered instruction word
//   instr_ready               : high only in IDLE and out of reset
//   alu_opcode/alu_a/alu_b/   : operands to the ALU; opcode is NOP outside
//   alu_imm                     ISSUE, operand buses hold their last value
//   alu_result                : ALU output, valid the cycle after ISSUE
//   done                      : one-cycle pulse during WRITEBACK
//   zero_flag                 : set by sub/subi on zero result, cleared by add/addi
//   illegal                   : one-cycle pulse after an unsupported opcode
//   dbg_addr/dbg_data         : combinational register read
// Sequence: accept (IDLE) -> ISSUE -> WRITEBACK -> IDLE, one instr per 3 cycles.
// ---------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  input  logic [XLEN-1:0]        instr,
  output logic                   instr_ready,
  output logic [3:0]             alu_opcode,
  output logic signed [XLEN-1:0] alu_a,
  output logic signed [XLEN-1:0] alu_b,
  output logic signed [XLEN-1:0] alu_imm,
  input  logic signed [XLEN-1:0] alu_result,
  output logic                   done,
  output logic                   zero_flag,
  output logic                   illegal,
  input  logic [REG_AW-1:0]      dbg_addr,
  output logic [XLEN-1:0]        dbg_data
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [3:0]        alu_opcode_q, alu_opcode_d;
  logic [XLEN-1:0]   alu_a_q, alu_a_d;
  logic [XLEN-1:0]   alu_b_q, alu_b_d;
  logic [XLEN-1:0]   alu_imm_q, alu_imm_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              zero_q, zero_d;

  instr_t          dec;
  logic            transfer;
  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;
  logic            rf_we;

  assign dec         = decode(instr);
  assign instr_ready = !rst && (state_q == ST_IDLE);
  assign transfer    = instr_valid && instr_ready;

  // Operands are read with the incoming instruction's fields at the accepting
  // edge. No write can land between that edge and ISSUE, so the captured
  // values equal the register contents seen during ISSUE.
  assign rf_we = (state_q == ST_WRITEBACK);

  alu_issue_ctrl_regfile #(
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (alu_result),
    .raddr_a  (dec.rs),
    .rdata_a  (rf_a),
    .raddr_b  (dec.rt),
    .rdata_b  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rd_d         = rd_q;
    alu_opcode_d = OP_NOP;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_imm_d    = alu_imm_q;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    zero_d       = zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          if (is_supported(dec.opcode)) begin
            state_d      = ST_ISSUE;
            op_d         = dec.opcode;
            rd_d         = dec.rd;
            alu_opcode_d = dec.opcode;
            alu_a_d      = rf_a;
            alu_b_d      = rf_b;
            alu_imm_d    = sext6(dec.imm6);
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WRITEBACK;
        done_d  = 1'b1;
      end
      ST_WRITEBACK: begin
        state_d = ST_IDLE;
        zero_d  = is_sub(op_q) ? (alu_result == '0) : 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset has priority, so an instruction in flight is dropped without done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_NOP;
      rd_q         <= '0;
      alu_opcode_q <= OP_NOP;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_imm_q    <= '0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_imm_q    <= alu_imm_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
      zero_q       <= zero_d;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_imm    = alu_imm_q;
  assign done       = done_q;
  assign illegal    = illegal_q;
  assign zero_flag  = zero_q;

endmodule
